// File: rtl/wallace_final_adder.sv
// Segmented carry-propagate adder that merges the Wallace tree sum/carry rows.
// Each stage ripples SEG_W bits and hands its carry to the next stage through a register.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module seg_adder #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co
);
    logic [SEG_W:0] c;

    assign c[0] = ci;
    for (genvar i = 0; i < SEG_W; i++) begin : g_fa
        full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end
    assign co = c[SEG_W];
endmodule

module wallace_final_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8,
    localparam int NUM_SEG = WIDTH / SEG_W,
    localparam int OCC_W = $clog2(NUM_SEG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_row,
    input  logic [WIDTH-1:0] carry_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [OCC_W-1:0] occupancy
);
    localparam logic [OCC_W-1:0] OCC_ONE = 1;

    logic adv, accept, emit;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign emit     = out_valid && out_ready;

    // Stage k keeps only the (k+1) finished low segments and the still-unadded upper operand bits.
    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stg
        localparam int LO  = k * SEG_W;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]      pa, pb;
        logic                pv, pcy;
        logic [LO+SEG_W-1:0] nacc, acc;
        logic [SEG_W-1:0]    seg_s;
        logic                seg_co;
        logic                vld, cy;

        if (k == 0) begin : g_in
            assign pa   = sum_row;
            assign pb   = carry_row;
            assign pv   = in_valid;
            assign pcy  = 1'b0;
            assign nacc = seg_s;
        end else begin : g_in
            assign pa   = g_stg[k-1].g_skew.opa;
            assign pb   = g_stg[k-1].g_skew.opb;
            assign pv   = g_stg[k-1].vld;
            assign pcy  = g_stg[k-1].cy;
            assign nacc = {seg_s, g_stg[k-1].acc};
        end

        seg_adder #(.SEG_W(SEG_W)) u_seg (
            .a (pa[SEG_W-1:0]),
            .b (pb[SEG_W-1:0]),
            .ci(pcy),
            .s (seg_s),
            .co(seg_co)
        );

        // Data only loads for valid entries so idle-cycle garbage never enters the pipe.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= 1'b0;
                cy  <= 1'b0;
                acc <= '0;
            end else if (adv) begin
                vld <= pv;
                if (pv) begin
                    acc <= nacc;
                    cy  <= seg_co;
                end
            end
        end

        if (k < NUM_SEG - 1) begin : g_skew
            logic [REM-SEG_W-1:0] opa, opb;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opa <= '0;
                    opb <= '0;
                end else if (adv && pv) begin
                    opa <= pa[REM-1:SEG_W];
                    opb <= pb[REM-1:SEG_W];
                end
            end
        end
    end

    assign out_valid = g_stg[NUM_SEG-1].vld;
    assign result    = g_stg[NUM_SEG-1].acc;
    assign cout      = g_stg[NUM_SEG-1].cy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            case ({accept, emit})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end
endmodule
